// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues a memory read for pc_in, captures the word into ir and offers pc_next.
// Optional memory-wait timeout enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    input  logic        fetch_req,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_take,
    output logic [15:0] pc_next,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] addr_r;
    logic [15:0] ir_r;
    logic [15:0] pc_next_r;
    logic        accept;
    logic        capture;
    logic        timeout;

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcount;
    logic          err_r;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    accept   = 1'b1;
                    state_nx = READ;
                end
            end
            READ: begin
                // mem_ready wins over an expiring timeout in the same cycle
                if (mem_ready) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (tcount == TLAST) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            HOLD: begin
                if (ir_take) begin
                    if (fetch_req) begin
                        accept   = 1'b1;
                        state_nx = READ;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r    <= '0;
            ir_r      <= '0;
            pc_next_r <= '0;
        end else begin
            if (accept) begin
                addr_r <= pc_in;
            end
            if (capture) begin
                ir_r      <= mem_rdata;
                pc_next_r <= addr_r + 16'd1;
            end
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tcount <= '0;
            err_r  <= 1'b0;
        end else begin
            if (accept) begin
                tcount <= '0;
            end else if (state == READ && !mem_ready) begin
                tcount <= tcount + 1'b1;
            end
            if (accept) begin
                err_r <= 1'b0;
            end else if (timeout) begin
                err_r <= 1'b1;
            end
        end
    end

    assign fetch_err = err_r;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_addr = addr_r;
    assign mem_rd   = (state == READ);
    assign busy     = (state == READ);
    assign ir       = ir_r;
    assign ir_valid = (state == HOLD);
    assign pc_next  = pc_next_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; the timeout section follows IFETCH_TIMEOUT_EN.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        fetch_req;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_take;
    logic [15:0] pc_next;
    logic        busy;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ifetch_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .fetch_req (fetch_req),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_take   (ir_take),
        .pc_next   (pc_next),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        pc_in     = 16'h0000;
        fetch_req = 1'b0;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        ir_take   = 1'b0;
        tick();
        tick();
        chk("rst_mem_rd",   {31'd0, mem_rd},    32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid},  32'd0);
        chk("rst_ir",       {16'd0, ir},        32'h0000);
        chk("rst_pc_next",  {16'd0, pc_next},   32'h0000);
        chk("rst_mem_addr", {16'd0, mem_addr},  32'h0000);
        chk("rst_err",      {31'd0, fetch_err}, 32'd0);
        reset = 1'b0;

        // basic fetch: ready arrives in the third READ cycle
        pc_in     = 16'h0010;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f1_rd_c1",    {31'd0, mem_rd},   32'd1);
        chk("f1_addr_c1",  {16'd0, mem_addr}, 32'h0010);
        chk("f1_busy_c1",  {31'd0, busy},     32'd1);
        chk("f1_valid_c1", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("f1_rd_c2",    {31'd0, mem_rd},   32'd1);
        tick();
        chk("f1_rd_c3",    {31'd0, mem_rd},   32'd1);
        chk("f1_addr_c3",  {16'd0, mem_addr}, 32'h0010);
        mem_ready = 1'b1;
        mem_rdata = 16'hA5C3;
        tick();
        mem_ready = 1'b0;
        chk("f1_ir",       {16'd0, ir},       32'hA5C3);
        chk("f1_valid",    {31'd0, ir_valid}, 32'd1);
        chk("f1_pc_next",  {16'd0, pc_next},  32'h0011);
        chk("f1_rd_done",  {31'd0, mem_rd},   32'd0);
        chk("f1_busy_done", {31'd0, busy},    32'd0);

        // stall in HOLD: fetch_req and stray mem_ready ignored
        ir_take   = 1'b0;
        fetch_req = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ir",    {16'd0, ir},       32'hA5C3);
            chk("hold_rd",    {31'd0, mem_rd},   32'd0);
            chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        end
        mem_ready = 1'b0;
        ir_take   = 1'b1;
        pc_in     = 16'h0011;
        tick();
        ir_take   = 1'b0;
        fetch_req = 1'b0;
        chk("b2b_rd",      {31'd0, mem_rd},   32'd1);
        chk("b2b_addr",    {16'd0, mem_addr}, 32'h0011);
        chk("b2b_valid",   {31'd0, ir_valid}, 32'd0);
        chk("b2b_ir_held", {16'd0, ir},       32'hA5C3);
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        tick();
        mem_ready = 1'b0;
        chk("b2b_ir",      {16'd0, ir},       32'h5A5A);
        chk("b2b_pc_next", {16'd0, pc_next},  32'h0012);

        // take without a new request -> IDLE; take in IDLE is ignored
        ir_take = 1'b1;
        tick();
        chk("take_valid", {31'd0, ir_valid}, 32'd0);
        chk("take_rd",    {31'd0, mem_rd},   32'd0);
        chk("take_ir",    {16'd0, ir},       32'h5A5A);
        tick();
        chk("idle_take_valid", {31'd0, ir_valid}, 32'd0);
        ir_take = 1'b0;

        // address wrap
        pc_in     = 16'hFFFF;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("wrap_addr", {16'd0, mem_addr}, 32'hFFFF);
        mem_ready = 1'b1;
        mem_rdata = 16'h0F0F;
        tick();
        mem_ready = 1'b0;
        chk("wrap_pc_next", {16'd0, pc_next}, 32'h0000);
        chk("wrap_ir",      {16'd0, ir},      32'h0F0F);
        ir_take = 1'b1;
        tick();
        ir_take = 1'b0;

        // fetch_req ignored while READ is outstanding
        pc_in     = 16'h0100;
        fetch_req = 1'b1;
        tick();
        pc_in = 16'h0200;
        tick();
        fetch_req = 1'b0;
        chk("read_ign_addr", {16'd0, mem_addr}, 32'h0100);
        chk("read_ign_rd",   {31'd0, mem_rd},   32'd1);

        // reset in READ with coincident mem_ready
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        chk("rr_rd",      {31'd0, mem_rd},   32'd0);
        chk("rr_ir",      {16'd0, ir},       32'h0000);
        chk("rr_valid",   {31'd0, ir_valid}, 32'd0);
        chk("rr_pc_next", {16'd0, pc_next},  32'h0000);
        chk("rr_addr",    {16'd0, mem_addr}, 32'h0000);
        tick();
        chk("rr_rd_after", {31'd0, mem_rd},  32'd0);

        // prime ir/pc_next with a known capture, return to IDLE
        pc_in     = 16'h0020;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'h1357;
        tick();
        mem_ready = 1'b0;
        ir_take   = 1'b1;
        tick();
        ir_take   = 1'b0;
        chk("prime_ir", {16'd0, ir}, 32'h1357);

`ifdef IFETCH_TIMEOUT_EN
        pc_in     = 16'h0030;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("to_busy_c16", {31'd0, busy},      32'd1);
        chk("to_err_c16",  {31'd0, fetch_err}, 32'd0);
        tick();
        chk("to_err",      {31'd0, fetch_err}, 32'd1);
        chk("to_busy",     {31'd0, busy},      32'd0);
        chk("to_ir",       {16'd0, ir},        32'h1357);
        chk("to_pc_next",  {16'd0, pc_next},   32'h0021);
        tick();
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
        pc_in     = 16'h0040;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("to_err_clr", {31'd0, fetch_err}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_ready = 1'b0;
        chk("to_win_ir",    {16'd0, ir},        32'h2468);
        chk("to_win_err",   {31'd0, fetch_err}, 32'd0);
        chk("to_win_valid", {31'd0, ir_valid},  32'd1);
        chk("to_win_pc",    {16'd0, pc_next},   32'h0041);
`else
        pc_in     = 16'h0050;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("wait_busy", {31'd0, busy},      32'd1);
        chk("wait_err",  {31'd0, fetch_err}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_ready = 1'b0;
        chk("wait_ir", {16'd0, ir},      32'h2468);
        chk("wait_pc", {16'd0, pc_next}, 32'h0051);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
